pingpong_pixel_buffer: RTL and testbench
========================================

Name: pingpong_pixel_buffer

Overview:
- Double-buffered (ping-pong) pixel store for the display path. Replaces the single-bank RGB buffer.
- The writer fills the back bank while the scan-out reader reads the front bank. A swap request exchanges the banks at the next cycle when both ports are idle.
- Generalised in channel count, channel width and depth. Adds per-channel write masking, registered reads with a valid flag, and address range checking.

Parameters:
- CH_W, 8, bits per colour channel
- NUM_CH, 3, channels per pixel; channel 0 occupies the LSBs (B=0, G=1, R=2 for RGB)
- DEPTH, 10000, pixels per bank
- ADDR_W, 20, address width; DEPTH <= 2**ADDR_W

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- wr_en  in  1  write strobe (back bank)
- wr_addr  in  ADDR_W  write pixel address
- wr_data  in  NUM_CH*CH_W  packed pixel, channel k at [k*CH_W +: CH_W]
- wr_mask  in  NUM_CH  per-channel write enable; 1 = write that channel
- rd_en  in  1  read strobe (front bank)
- rd_addr  in  ADDR_W  read pixel address
- rd_data  out  NUM_CH*CH_W  registered read data, same packing as wr_data
- rd_valid  out  1  high for one cycle when rd_data is updated
- swap_req  in  1  request bank exchange (level or pulse)
- swap_ack  out  1  one-cycle pulse in the cycle front_sel toggles
- front_sel  out  1  index of the bank currently read (0 or 1)
- wr_err  out  1  one-cycle pulse: write dropped, address out of range
- rd_err  out  1  one-cycle pulse, coincident with rd_valid: read address out of range

Behaviour:
- Reset values:
  - rd_data=0, rd_valid=0, rd_err=0, wr_err=0, swap_ack=0, front_sel=0
  - FSM in IDLE
  - Bank contents are not cleared.
- Write (cycle N, wr_en=1, wr_addr<DEPTH):
  - Back bank (bank !front_sel) at wr_addr is updated only in channels with wr_mask[k]=1; other channels keep their old value.
  - Visible to reads from cycle N+1 onward, once that bank becomes the front bank.
- Read (cycle N, rd_en=1):
  - At cycle N+1: rd_data = front bank[rd_addr], rd_valid=1.
  - Fixed latency of 1 cycle. Back-to-back reads give one result per cycle.
  - When rd_en=0, rd_valid=0 and rd_data holds its last value.
- Range check:
  - wr_addr>=DEPTH: write dropped, wr_err=1 in cycle N+1.
  - rd_addr>=DEPTH: rd_data=0, rd_valid=1, rd_err=1 in cycle N+1.
- wr_en and rd_en in the same cycle are legal and independent. They target different banks, so there is no collision.
- Swap FSM states:
  - IDLE: swap_req=1 -> PEND.
  - PEND: first cycle with wr_en=0 and rd_en=0 -> front_sel toggles at the clock edge ending that cycle. swap_ack=1 in the following cycle. Return to IDLE.
  - Any read issued before the toggle edge returns data from the old front bank, including its result in the following cycle.
  - Any write issued before the toggle edge goes to the old back bank.
  - swap_req while in PEND is coalesced: one swap, one ack.
  - swap_req held high after the ack starts a new request from IDLE in the next cycle.
  - swap_req and both ports idle in the same IDLE cycle: the swap takes 2 cycles (IDLE->PEND, then toggle). Minimum request-to-ack latency is 3 cycles.
- Reset while in PEND: the pending swap is discarded, front_sel=0, no ack. An in-flight read result is discarded (rd_valid=0).
- Address arithmetic: no wrap. Out-of-range addresses are never folded modulo DEPTH.

Decomposition:
- Shared package pixel_pkg:
  - default CH_W, NUM_CH
  - channel index constants CH_B=0, CH_G=1, CH_R=2
  - swap FSM state enum {IDLE, PEND}
- Sub-module pixel_bank, instantiated twice:
  - one write port with per-channel mask
  - one registered read port
  - parameters CH_W, NUM_CH, DEPTH, ADDR_W
- The top level contains bank steering by front_sel, the range checks, the swap FSM and the output registers.

Test Plan:
- Reset, then write 0x112233 at addr 5 (mask 3'b111), request swap with ports idle, read addr 5 -> swap_ack 3 cycles after swap_req; one cycle after the read, rd_data=0x112233, rd_valid=1, front_sel=1.
- Masked write: 0xAABBCC to addr 7 of the back bank, then 0x000000 to addr 7 with mask 3'b010, then swap and read addr 7 -> rd_data=0xAA00CC.
- Swap deferral: hold rd_en=1 for 10 cycles with swap_req pulsed in cycle 2 -> front_sel unchanged and no ack until rd_en drops; all 10 reads return old-front data; exactly one swap_ack.
- Range: write to addr 10000 -> wr_err pulse, no bank change. Read addr 10000 -> rd_data=0, rd_valid=1, rd_err=1. Addr 9999 works normally.
- Concurrency: write addr 3=0x010203 and read addr 3 in the same cycle -> rd_data shows the front bank's old value at addr 3; after a swap, a read of addr 3 returns 0x010203.
- Reset in PEND: swap_req while rd_en=1, assert reset for one cycle -> front_sel=0, no swap_ack, rd_valid=0.

Source files
------------

// File: rtl/pixel_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_pkg
// Brief    : Shared pixel types: default geometry, channel indices, swap states
// Revision : 1.0
// ============================================================================
package pixel_pkg;

   localparam int DEF_CH_W   = 8;
   localparam int DEF_NUM_CH = 3;

   localparam int CH_B = 0;
   localparam int CH_G = 1;
   localparam int CH_R = 2;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      PEND = 1'b1
   } swap_state_t;

endpackage
`default_nettype wire

// File: rtl/pixel_bank.sv
`default_nettype none
// ============================================================================
// Module   : pixel_bank
// Brief    : Single pixel bank, channel-masked write port, registered read port
// Revision : 1.0
// ============================================================================
module pixel_bank
   import pixel_pkg::*;
#(
   parameter int CH_W   = DEF_CH_W,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DEPTH  = 10000,
   parameter int ADDR_W = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [NUM_CH*CH_W-1:0]   wr_data,
   input  logic [NUM_CH-1:0]        wr_mask,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [NUM_CH*CH_W-1:0]   rd_data
);

   localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [NUM_CH*CH_W-1:0] r_mem [DEPTH];
   logic [NUM_CH*CH_W-1:0] r_rd_data;
   logic [c_IDX_W-1:0]     w_wr_idx;
   logic [c_IDX_W-1:0]     w_rd_idx;

   // Callers only strobe in-range addresses, so the upper bits carry nothing.
   assign w_wr_idx = wr_addr[c_IDX_W-1:0];
   assign w_rd_idx = rd_addr[c_IDX_W-1:0];

   generate
      if (c_IDX_W < ADDR_W) begin : g_addr_hi
         logic w_unused_hi;
         assign w_unused_hi = ^{wr_addr[ADDR_W-1:c_IDX_W], rd_addr[ADDR_W-1:c_IDX_W]};
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (wr_mask[k]) begin
               r_mem[w_wr_idx][k*CH_W +: CH_W] <= wr_data[k*CH_W +: CH_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_data <= '0;
      end else if (rd_en) begin
         r_rd_data <= r_mem[w_rd_idx];
      end
   end

   assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/pingpong_pixel_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pingpong_pixel_buffer
// Brief    : Ping-pong pixel store: writer fills back bank, reader scans front
// Revision : 1.0
// ============================================================================
module pingpong_pixel_buffer
   import pixel_pkg::*;
#(
   parameter int CH_W   = DEF_CH_W,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DEPTH  = 10000,
   parameter int ADDR_W = 20
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [NUM_CH*CH_W-1:0]   wr_data,
   input  logic [NUM_CH-1:0]        wr_mask,
   input  logic                     rd_en,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic [NUM_CH*CH_W-1:0]   rd_data,
   output logic                     rd_valid,
   input  logic                     swap_req,
   output logic                     swap_ack,
   output logic                     front_sel,
   output logic                     wr_err,
   output logic                     rd_err
);

   localparam int              c_PIX_W = NUM_CH * CH_W;
   // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

   swap_state_t        r_state;
   swap_state_t        w_state_nxt;
   logic               w_do_swap;
   logic               w_wr_ok;
   logic               w_rd_ok;
   logic               r_front_sel;
   logic               r_swap_ack;
   logic               r_wr_err;
   logic               r_rd_err;
   logic               r_rd_valid;
   logic               r_rd_bank;
   logic               r_rd_zero;
   logic [c_PIX_W-1:0] w_bank_q [2];

   assign w_wr_ok = ({1'b0, wr_addr} < c_DEPTH);
   assign w_rd_ok = ({1'b0, rd_addr} < c_DEPTH);

   generate
      for (genvar b = 0; b < 2; b++) begin : g_bank
         pixel_bank #(
            .CH_W   (CH_W),
            .NUM_CH (NUM_CH),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
         ) u_bank (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (wr_en && w_wr_ok && (r_front_sel != 1'(b))),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .wr_mask (wr_mask),
            .rd_en   (rd_en && w_rd_ok && (r_front_sel == 1'(b))),
            .rd_addr (rd_addr),
            .rd_data (w_bank_q[b])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Swap only in a cycle with both ports idle, so no access straddles the toggle.
   always_comb begin
      w_state_nxt = r_state;
      w_do_swap   = 1'b0;
      case (r_state)
         IDLE: begin
            if (swap_req) begin
               w_state_nxt = PEND;
            end
         end
         PEND: begin
            if (!wr_en && !rd_en) begin
               w_do_swap   = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_front_sel <= 1'b0;
         r_swap_ack  <= 1'b0;
         r_wr_err    <= 1'b0;
         r_rd_err    <= 1'b0;
         r_rd_valid  <= 1'b0;
         r_rd_bank   <= 1'b0;
         r_rd_zero   <= 1'b1;
      end else begin
         r_front_sel <= r_front_sel ^ w_do_swap;
         r_swap_ack  <= w_do_swap;
         r_wr_err    <= wr_en && !w_wr_ok;
         r_rd_err    <= rd_en && !w_rd_ok;
         r_rd_valid  <= rd_en;
         if (rd_en) begin
            r_rd_bank <= r_front_sel;
            r_rd_zero <= !w_rd_ok;
         end
      end
   end

   // Bank read registers hold between reads, so rd_data holds too.
   assign rd_data   = r_rd_zero ? '0 : w_bank_q[r_rd_bank];
   assign rd_valid  = r_rd_valid;
   assign rd_err    = r_rd_err;
   assign wr_err    = r_wr_err;
   assign swap_ack  = r_swap_ack;
   assign front_sel = r_front_sel;

endmodule
`default_nettype wire

// File: tb/tb_pingpong_pixel_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pingpong_pixel_buffer
// Brief    : Directed self-checking bench with a bank-level reference model
// Revision : 1.0
// ============================================================================
module tb_pingpong_pixel_buffer;

   localparam int DEPTH = 10000;
   localparam int PW    = 24;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [19:0]   wr_addr;
   logic [PW-1:0] wr_data;
   logic [2:0]    wr_mask;
   logic          rd_en;
   logic [19:0]   rd_addr;
   logic [PW-1:0] rd_data;
   logic          rd_valid;
   logic          swap_req;
   logic          swap_ack;
   logic          front_sel;
   logic          wr_err;
   logic          rd_err;

   int checks   = 0;
   int failures = 0;

   pingpong_pixel_buffer #(
      .CH_W (8), .NUM_CH (3), .DEPTH (DEPTH), .ADDR_W (20)
   ) dut (
      .clk (clk), .reset (reset),
      .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .wr_mask (wr_mask),
      .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data), .rd_valid (rd_valid),
      .swap_req (swap_req), .swap_ack (swap_ack), .front_sel (front_sel),
      .wr_err (wr_err), .rd_err (rd_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: banks as sparse pixel maps -------------
   logic [PW-1:0] mb0 [int];
   logic [PW-1:0] mb1 [int];
   logic          m_live = 1'b0;
   logic          m_front, m_pend;
   logic          e_valid, e_err, e_werr, e_ack, e_known;
   logic [PW-1:0] e_data;
   logic [PW-1:0] m_old;

   function automatic logic [PW-1:0] merge(input logic [PW-1:0] o, input logic [PW-1:0] n,
                                           input logic [2:0] m);
      logic [PW-1:0] r;
      r = o;
      for (int k = 0; k < 3; k++) if (m[k]) r[k*8 +: 8] = n[k*8 +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         e_valid = 0; e_err = 0; e_werr = 0; e_ack = 0; e_data = '0; e_known = 1;
         m_front = 0; m_pend = 0; m_live = 1;
      end else if (m_live) begin
         e_werr = wr_en && (int'(wr_addr) >= DEPTH);
         if (wr_en && int'(wr_addr) < DEPTH) begin
            if (m_front) begin
               m_old = mb0.exists(int'(wr_addr)) ? mb0[int'(wr_addr)] : '0;
               mb0[int'(wr_addr)] = merge(m_old, wr_data, wr_mask);
            end else begin
               m_old = mb1.exists(int'(wr_addr)) ? mb1[int'(wr_addr)] : '0;
               mb1[int'(wr_addr)] = merge(m_old, wr_data, wr_mask);
            end
         end
         if (rd_en) begin
            e_valid = 1;
            if (int'(rd_addr) >= DEPTH) begin
               e_err = 1; e_data = '0; e_known = 1;
            end else begin
               e_err = 0;
               if (!m_front && mb0.exists(int'(rd_addr))) begin
                  e_data = mb0[int'(rd_addr)]; e_known = 1;
               end else if (m_front && mb1.exists(int'(rd_addr))) begin
                  e_data = mb1[int'(rd_addr)]; e_known = 1;
               end else begin
                  e_known = 0;
               end
            end
         end else begin
            e_valid = 0; e_err = 0;
         end
         e_ack = m_pend && !wr_en && !rd_en;
         if (e_ack) begin
            m_pend = 0; m_front = !m_front;
         end else if (swap_req) begin
            m_pend = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("cyc_rd_valid",  32'(rd_valid),  32'(e_valid));
         chk("cyc_rd_err",    32'(rd_err),    32'(e_err));
         chk("cyc_wr_err",    32'(wr_err),    32'(e_werr));
         chk("cyc_swap_ack",  32'(swap_ack),  32'(e_ack));
         chk("cyc_front_sel", 32'(front_sel), 32'(m_front));
         if (e_known) chk("cyc_rd_data", 32'(rd_data), 32'(e_data));
      end
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic drive_idle();
      wr_en = 0; wr_addr = '0; wr_data = '0; wr_mask = '0;
      rd_en = 0; rd_addr = '0; swap_req = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [19:0] a, input logic [PW-1:0] d, input logic [2:0] m);
      wr_en = 1; wr_addr = a; wr_data = d; wr_mask = m;
      tick();
      drive_idle();
   endtask

   task automatic do_read(input logic [19:0] a);
      rd_en = 1; rd_addr = a;
      tick();
      drive_idle();
   endtask

   task automatic do_swap(output int cycles);
      swap_req = 1;
      tick();
      swap_req = 0;
      cycles = 1;
      while (!swap_ack && cycles < 12) begin
         tick();
         cycles++;
      end
      chk("swap_ack_seen", 32'(swap_ack), 32'd1);
   endtask

   int lat;
   int acks;

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      drive_idle();
      reset = 1;
      repeat (3) tick();
      reset = 0;
      chk("reset_rd_data",   32'(rd_data),   32'h0);
      chk("reset_rd_valid",  32'(rd_valid),  32'h0);
      chk("reset_front_sel", 32'(front_sel), 32'h0);
      chk("reset_swap_ack",  32'(swap_ack),  32'h0);

      // Basic write, swap with idle ports, read back.
      do_write(20'd5, 24'h112233, 3'b111);
      do_write(20'd3, 24'h0A0B0C, 3'b111);
      do_swap(lat);
      chk("swap_latency_incl", 32'(lat + 1), 32'd3);
      chk("front_after_swap1", 32'(front_sel), 32'd1);
      do_read(20'd5);
      chk("basic_rd_data",  32'(rd_data),  32'h112233);
      chk("basic_rd_valid", 32'(rd_valid), 32'd1);

      // Channel-masked write into bank 0.
      do_write(20'd7, 24'hAABBCC, 3'b111);
      do_write(20'd7, 24'h000000, 3'b010);
      do_write(20'd3, 24'h0D0E0F, 3'b111);
      do_swap(lat);
      do_read(20'd7);
      chk("masked_rd_data", 32'(rd_data), 32'hAA00CC);

      // Swap deferred by a 10-cycle read burst.
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         rd_en = 1; rd_addr = (i % 2 == 1) ? 20'd3 : 20'd7; swap_req = (i == 2);
         tick();
         acks += int'(swap_ack);
         chk("defer_front_held", 32'(front_sel), 32'd0);
      end
      chk("defer_last_rd_data", 32'(rd_data), 32'h0D0E0F);
      drive_idle();
      repeat (5) begin
         tick();
         acks += int'(swap_ack);
      end
      chk("defer_ack_count", 32'(acks), 32'd1);
      chk("defer_front_new", 32'(front_sel), 32'd1);

      // Range checks and the last legal address.
      do_write(20'd10000, 24'hFFFFFF, 3'b111);
      chk("range_wr_err", 32'(wr_err), 32'd1);
      do_write(20'd9999, 24'h123456, 3'b111);
      chk("range_wr_ok", 32'(wr_err), 32'd0);
      do_read(20'd10000);
      chk("range_rd_data",  32'(rd_data),  32'h0);
      chk("range_rd_valid", 32'(rd_valid), 32'd1);
      chk("range_rd_err",   32'(rd_err),   32'd1);
      do_swap(lat);
      do_read(20'd9999);
      chk("range_9999_data", 32'(rd_data), 32'h123456);
      chk("range_9999_err",  32'(rd_err),  32'd0);

      // Simultaneous write and read of the same address hit different banks.
      wr_en = 1; wr_addr = 20'd3; wr_data = 24'h010203; wr_mask = 3'b111;
      rd_en = 1; rd_addr = 20'd3;
      tick();
      drive_idle();
      chk("conc_old_front", 32'(rd_data), 32'h0D0E0F);
      do_swap(lat);
      do_read(20'd3);
      chk("conc_after_swap", 32'(rd_data), 32'h010203);

      // Reset while a swap is pending and a read is in flight.
      rd_en = 1; rd_addr = 20'd5; swap_req = 1;
      tick();
      drive_idle();
      reset = 1;
      tick();
      reset = 0;
      chk("rstpend_front", 32'(front_sel), 32'd0);
      chk("rstpend_ack",   32'(swap_ack),  32'd0);
      chk("rstpend_valid", 32'(rd_valid),  32'd0);
      acks = 0;
      repeat (4) begin
         tick();
         acks += int'(swap_ack);
      end
      chk("rstpend_no_ack", 32'(acks), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
